// File: rtl/instr_mem_loadable.sv
// Host-loadable instruction memory: a valid/ready load port fills the array, then the fetch
// stage reads it through a registered request/response port with misalign/bounds faults.
module instr_mem_loadable #(
    parameter int unsigned INST_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [INST_WIDTH-1:0]          load_data,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           load_done,
    output logic [$clog2(DEPTH+1)-1:0]     prog_len,
    input  logic                           fetch_req,
    input  logic [ADDR_WIDTH-1:0]          fetch_addr,
    output logic                           fetch_ready,
    output logic                           fetch_valid,
    output logic [INST_WIDTH-1:0]          fetch_inst,
    output logic                           fetch_fault
);

    localparam int unsigned ALIGN_BITS = $clog2(INST_WIDTH / 8);
    localparam int unsigned IDX_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);

    typedef enum logic [1:0] {StEmpty, StLoad, StRun} state_e;

    state_e                 state_q, state_d;
    logic [INST_WIDTH-1:0]  mem [DEPTH];
    logic [IDX_W-1:0]       wptr_q;
    logic [CNT_W-1:0]       prog_len_q;
    logic                   load_done_q;
    logic                   fetch_valid_q;
    logic                   fetch_fault_q;
    logic [INST_WIDTH-1:0]  fetch_inst_q;

    logic                   load_acc;
    logic                   load_fin;
    logic                   fetch_acc;
    logic                   fetch_bad;
    logic [31:0]            fetch_idx;

    assign load_acc  = load_valid & load_ready;
    // The last array slot ends the load even without load_last, so writes never wrap.
    assign load_fin  = load_acc & (load_last | (wptr_q == IDX_W'(DEPTH - 1)));
    assign fetch_acc = fetch_req & fetch_ready;

    always_comb begin
        fetch_idx = 32'(fetch_addr) >> ALIGN_BITS;
        fetch_bad = ((fetch_addr & ALIGN_MASK) != '0) || (fetch_idx >= 32'(prog_len_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (load_start) state_d = StLoad;
            StLoad:  if (!load_start && load_fin) state_d = StRun;
            StRun:   if (load_start) state_d = StLoad;
            default: state_d = StEmpty;
        endcase
    end

    // Readiness depends only on state and load_start, never on the requester's valid.
    always_comb begin
        load_ready  = (state_q == StLoad) && !load_start;
        fetch_ready = (state_q == StRun) && !load_start;
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem[wptr_q] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q        <= '0;
            prog_len_q    <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_inst_q  <= '0;
        end else begin
            load_done_q   <= load_fin;
            fetch_valid_q <= fetch_acc;
            if (load_start) begin
                wptr_q     <= '0;
                prog_len_q <= '0;
            end else if (load_acc) begin
                wptr_q <= wptr_q + IDX_W'(1);
                if (load_fin) begin
                    prog_len_q <= CNT_W'(wptr_q) + CNT_W'(1);
                end
            end
            if (fetch_acc) begin
                fetch_fault_q <= fetch_bad;
                fetch_inst_q  <= fetch_bad ? '0 : mem[fetch_idx[IDX_W-1:0]];
            end
        end
    end

    assign load_done   = load_done_q;
    assign prog_len    = prog_len_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_inst  = fetch_inst_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: reset, loads, fetches, faults, restarts and
// asynchronous reset, each scenario checked against hand-computed values.
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start, load_valid, load_last;
    logic [15:0] load_data;
    logic        load_ready, load_done;
    logic [4:0]  prog_len;
    logic        fetch_req;
    logic [4:0]  fetch_addr;
    logic        fetch_ready, fetch_valid, fetch_fault;
    logic [15:0] fetch_inst;

    int n_tests = 0;
    int n_fail  = 0;

    instr_mem_loadable #(
        .INST_WIDTH (16),
        .DEPTH      (16),
        .ADDR_WIDTH (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .prog_len    (prog_len),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] outs;
        reset = 1'b1;
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0;
        tick(); tick();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = 5'd0;
            tick();
            outs = {load_ready, load_done, fetch_ready, fetch_valid, fetch_fault, fetch_inst,
                    prog_len};
            n_tests++;
            if (outs !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %h want 0", i, outs);
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_load4();
        logic [15:0] words [4] = '{16'h1123, 16'h2456, 16'h4789, 16'h5ABC};
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = words[i]; load_last = (i == 3);
            #1;
            n_tests++;
            if (load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load4_ready[%0d]: got %b want 1", i, load_ready);
            end
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        n_tests++;
        if ({load_done, fetch_ready, prog_len} !== {1'b1, 1'b1, 5'd4}) begin
            n_fail++;
            $display("FAIL load4_done: got done=%b fready=%b len=%0d want 1 1 4",
                     load_done, fetch_ready, prog_len);
        end
        // First fetch issued in the same cycle load_done is high.
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_addr = 5'(2 * i);
            tick();
            n_tests++;
            if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, 1'b0, words[i]}) begin
                n_fail++;
                $display("FAIL fetch4[%0d]: got v=%b f=%b inst=%h want 1 0 %h",
                         i, fetch_valid, fetch_fault, fetch_inst, words[i]);
            end
        end
        n_tests++;
        if (load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL load4_done_pulse: got %b want 0", load_done);
        end
        fetch_req = 1'b0;
        tick();
        n_tests++;
        if ({fetch_valid, fetch_inst} !== {1'b0, 16'h5ABC}) begin
            n_fail++;
            $display("FAIL fetch_idle_hold: got v=%b inst=%h want 0 5abc", fetch_valid, fetch_inst);
        end
    endtask

    task automatic test_faults();
        logic [4:0]  addrs [3] = '{5'd3, 5'd8, 5'd6};
        logic [16:0] exp   [3] = '{{1'b1, 16'h0}, {1'b1, 16'h0}, {1'b0, 16'h5ABC}};
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = addrs[i];
            tick();
            n_tests++;
            if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL fault[addr=%0d]: got v=%b f=%b inst=%h want 1 %b %h", addrs[i],
                         fetch_valid, fetch_fault, fetch_inst, exp[i][16], exp[i][15:0]);
            end
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_full_depth();
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            load_valid = 1'b1; load_data = 16'hA000 + 16'(i); load_last = 1'b0;
            if (i == 15) begin
                #1;
                n_tests++;
                if (load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_ready_beat16: got %b want 1", load_ready);
                end
            end
            tick();
        end
        load_valid = 1'b0;
        n_tests++;
        if ({load_ready, fetch_ready, load_done, prog_len} !== {1'b0, 1'b1, 1'b1, 5'd16}) begin
            n_fail++;
            $display("FAIL full_run: got lready=%b fready=%b done=%b len=%0d want 0 1 1 16",
                     load_ready, fetch_ready, load_done, prog_len);
        end
        fetch_req = 1'b1; fetch_addr = 5'd30;
        tick();
        fetch_req = 1'b0;
        n_tests++;
        if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, 1'b0, 16'hA00F}) begin
            n_fail++;
            $display("FAIL full_fetch30: got v=%b f=%b inst=%h want 1 0 a00f",
                     fetch_valid, fetch_fault, fetch_inst);
        end
        tick();
    endtask

    task automatic test_restart_load();
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_data = 16'h0111; tick();
        load_start = 1'b1; load_data = 16'h0222;
        #1;
        n_tests++;
        if (load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ready: got %b want 0", load_ready);
        end
        tick();
        load_start = 1'b0; load_data = 16'h0333; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        n_tests++;
        if ({load_done, prog_len} !== {1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL restart_len: got done=%b len=%0d want 1 1", load_done, prog_len);
        end
        fetch_req = 1'b1; fetch_addr = 5'd0;
        tick();
        n_tests++;
        if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, 1'b0, 16'h0333}) begin
            n_fail++;
            $display("FAIL restart_word0: got v=%b f=%b inst=%h want 1 0 0333",
                     fetch_valid, fetch_fault, fetch_inst);
        end
        fetch_addr = 5'd2;
        tick();
        fetch_req = 1'b0;
        n_tests++;
        if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL restart_bound: got v=%b f=%b inst=%h want 1 1 0000",
                     fetch_valid, fetch_fault, fetch_inst);
        end
    endtask

    task automatic test_start_vs_fetch();
        fetch_req = 1'b1; fetch_addr = 5'd0; load_start = 1'b1;
        #1;
        n_tests++;
        if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL startfetch_ready: got %b want 0", fetch_ready);
        end
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        #1;
        n_tests++;
        if ({fetch_valid, load_ready, prog_len} !== {1'b0, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL startfetch_next: got v=%b lready=%b len=%0d want 0 1 0",
                     fetch_valid, load_ready, prog_len);
        end
    endtask

    task automatic test_reset_midload();
        logic [25:0] outs;
        load_valid = 1'b1; load_data = 16'hBEE1; tick();
        load_data = 16'hBEE2; tick();
        load_data = 16'hBEE3;
        #2;
        reset = 1'b1;
        #1;
        outs = {load_ready, load_done, fetch_ready, fetch_valid, fetch_fault, fetch_inst, prog_len};
        n_tests++;
        if (outs !== 26'd0) begin
            n_fail++;
            $display("FAIL midload_reset: got %h want 0", outs);
        end
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fetch_req = 1'b1; fetch_addr = 5'd0;
        tick();
        n_tests++;
        if ({fetch_ready, fetch_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset_fetch: got rdy=%b v=%b want 0 0", fetch_ready, fetch_valid);
        end
        // Fetch stays blocked while reloading, then returns the new word.
        fetch_req = 1'b0; load_start = 1'b1; tick(); load_start = 1'b0;
        load_valid = 1'b1; load_data = 16'h7E57; load_last = 1'b1; fetch_req = 1'b1;
        #1;
        n_tests++;
        if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_fetch_block: got %b want 0", fetch_ready);
        end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        tick();
        n_tests++;
        if ({fetch_valid, fetch_fault, fetch_inst} !== {1'b1, 1'b0, 16'h7E57}) begin
            n_fail++;
            $display("FAIL reload_fetch: got v=%b f=%b inst=%h want 1 0 7e57",
                     fetch_valid, fetch_fault, fetch_inst);
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_midfetch();
        logic [25:0] outs;
        fetch_req = 1'b1; fetch_addr = 5'd0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        outs = {load_ready, load_done, fetch_ready, fetch_valid, fetch_fault, fetch_inst, prog_len};
        n_tests++;
        if (outs !== 26'd0) begin
            n_fail++;
            $display("FAIL midfetch_reset: got %h want 0", outs);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        fetch_req = 1'b0;
        n_tests++;
        if ({fetch_ready, fetch_valid, prog_len} !== {1'b0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL midfetch_after: got rdy=%b v=%b len=%0d want 0 0 0",
                     fetch_ready, fetch_valid, prog_len);
        end
    endtask

    initial begin
        test_reset();
        test_load4();
        test_faults();
        test_full_depth();
        test_restart_load();
        test_start_vs_fetch();
        test_reset_midload();
        test_reset_midfetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
